// File: rtl/priv_1_12_trap_ctrl.sv
// priv_1_12_trap_ctrl: machine-mode trap/mret sequencer (IDLE -> WAIT_CLEAR -> COMMIT -> REDIRECT).
// Define TRAP_VECTORED_EN to enable vectored interrupt targets when mtvec mode = 2'b01.
module priv_1_12_trap_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [15:0] exc_req,
  input  logic [11:0] mip_i,
  input  logic [11:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic        mstatus_mpie_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] tval_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        mret,
  input  logic        pipe_clear,
  output logic        busy,
  output logic        intr,
  output logic        inject,
  output logic [31:0] next_mcause,
  output logic [31:0] next_mepc,
  output logic [31:0] next_mtval,
  output logic        next_mstatus_mie,
  output logic        next_mstatus_mpie,
  output logic        insert_pc,
  output logic [31:0] priv_pc
);
  typedef enum logic [1:0] {IDLE, WAIT_CLEAR, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {K_EXC, K_INT, K_RET} kind_t;
  localparam logic [3:0] EXC_ORD [14] = '{4'd3, 4'd12, 4'd1, 4'd0, 4'd2, 4'd8, 4'd9, 4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};
  localparam logic [3:0] INT_ORD [6] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};
  state_t state, state_n;
  kind_t kind, new_kind, eff_kind;
  logic [3:0] lat_code, exc_code, int_code, new_code, eff_code;
  logic [31:0] lat_epc, lat_tval, new_tval, eff_epc, eff_tval, vec_off;
  logic [11:0] pend;
  logic lat_mie, eff_mie, exc_any, int_any, take, relatch;
  assign pend = mip_i & mie_i & 12'hAAA;
  assign exc_any = |(exc_req & 16'hBBFF);
  assign int_any = mstatus_mie_i & |pend;
  // Walk from lowest to highest priority so the highest set source wins.
  always_comb begin
    exc_code = '0;
    int_code = '0;
    for (int i = 13; i >= 0; i--) if (exc_req[EXC_ORD[i]]) exc_code = EXC_ORD[i];
    for (int i = 5; i >= 0; i--) if (pend[INT_ORD[i]]) int_code = INT_ORD[i];
  end
  assign new_kind = exc_any ? K_EXC : int_any ? K_INT : K_RET;
  assign new_code = exc_any ? exc_code : int_code;
  assign new_tval = exc_any ? tval_i : '0;
  // An exception arriving during the drain displaces a latched interrupt or mret.
  assign relatch = state == WAIT_CLEAR && exc_any && kind != K_EXC;
  assign take = (state == IDLE && (exc_any || int_any || mret)) || relatch;
  assign eff_kind = relatch ? K_EXC : kind;
  assign eff_code = relatch ? exc_code : lat_code;
  assign eff_epc = relatch ? epc_i : lat_epc;
  assign eff_tval = relatch ? tval_i : lat_tval;
  assign eff_mie = relatch ? mstatus_mie_i : lat_mie;
`ifdef TRAP_VECTORED_EN
  assign vec_off = (kind == K_INT && mtvec_i[1:0] == 2'b01) ? {26'b0, lat_code, 2'b00} : '0;
`else
  logic unused_mode;
  assign unused_mode = ^mtvec_i[1:0];
  assign vec_off = '0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (exc_any || int_any || mret) state_n = WAIT_CLEAR;
      WAIT_CLEAR: if (pipe_clear) state_n = COMMIT;
      COMMIT:     state_n = REDIRECT;
      REDIRECT:   state_n = IDLE;
    endcase
    busy = state != IDLE;
    intr = busy && kind != K_RET;
    inject = state == COMMIT;
    insert_pc = state == REDIRECT;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      kind <= K_EXC;
      lat_code <= '0;
      lat_epc <= '0;
      lat_tval <= '0;
      lat_mie <= 1'b0;
      next_mcause <= '0;
      next_mepc <= '0;
      next_mtval <= '0;
      next_mstatus_mie <= 1'b0;
      next_mstatus_mpie <= 1'b0;
      priv_pc <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        kind <= new_kind;
        lat_code <= new_code;
        lat_epc <= epc_i;
        lat_tval <= new_tval;
        lat_mie <= mstatus_mie_i;
      end
      if (state == WAIT_CLEAR && pipe_clear) begin
        if (eff_kind != K_RET) begin
          next_mcause <= {eff_kind == K_INT, 27'b0, eff_code};
          next_mepc <= eff_epc;
          next_mtval <= eff_tval;
        end
        next_mstatus_mie <= eff_kind == K_RET ? mstatus_mpie_i : 1'b0;
        next_mstatus_mpie <= eff_kind == K_RET ? 1'b1 : eff_mie;
      end
      if (state == COMMIT) priv_pc <= kind == K_RET ? mepc_i : {mtvec_i[31:2], 2'b00} + vec_off;
    end
endmodule

// File: tb/tb_priv_1_12_trap_ctrl.sv
// tb_priv_1_12_trap_ctrl: directed + randomized checks of the trap sequencer against a priority-list model.
module tb_priv_1_12_trap_ctrl;
  logic CLK = 0, nRST = 0;
  logic [15:0] exc_req = '0;
  logic [11:0] mip_i = '0, mie_i = '0;
  logic mstatus_mie_i = 0, mstatus_mpie_i = 0, mret = 0, pipe_clear = 0;
  logic [31:0] epc_i = '0, tval_i = '0, mtvec_i = '0, mepc_i = '0;
  logic busy, intr, inject, next_mstatus_mie, next_mstatus_mpie, insert_pc;
  logic [31:0] next_mcause, next_mepc, next_mtval, priv_pc;
  localparam int EXC_PRI [14] = '{3, 12, 1, 0, 2, 8, 9, 11, 6, 4, 15, 13, 7, 5};
  localparam int INT_PRI [6] = '{11, 3, 7, 9, 1, 5};
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_cause = '0, m_epc = '0, m_tval = '0;
  always #5 CLK = ~CLK;
  priv_1_12_trap_ctrl dut (
    .CLK(CLK), .nRST(nRST), .exc_req(exc_req), .mip_i(mip_i), .mie_i(mie_i),
    .mstatus_mie_i(mstatus_mie_i), .mstatus_mpie_i(mstatus_mpie_i), .epc_i(epc_i),
    .tval_i(tval_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mret(mret), .pipe_clear(pipe_clear),
    .busy(busy), .intr(intr), .inject(inject), .next_mcause(next_mcause), .next_mepc(next_mepc),
    .next_mtval(next_mtval), .next_mstatus_mie(next_mstatus_mie), .next_mstatus_mpie(next_mstatus_mpie),
    .insert_pc(insert_pc), .priv_pc(priv_pc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic clear_req;
    exc_req = '0;
    mip_i = '0;
    mie_i = '0;
    mret = 0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_intr"}, intr, 0);
    chk({tag, "_inject"}, inject, 0);
    chk({tag, "_insert"}, insert_pc, 0);
    chk({tag, "_mcause"}, next_mcause, 0);
    chk({tag, "_mepc"}, next_mepc, 0);
    chk({tag, "_mtval"}, next_mtval, 0);
    chk({tag, "_mie"}, next_mstatus_mie, 0);
    chk({tag, "_mpie"}, next_mstatus_mpie, 0);
    chk({tag, "_pc"}, priv_pc, 0);
  endtask
  task automatic txn(input logic [15:0] e, input logic [11:0] ip, input logic [11:0] ie,
                     input logic smie, input logic smpie, input logic [31:0] epc, input logic [31:0] tval,
                     input logic [31:0] tvec, input logic [31:0] mepcv, input logic mr, input int stall);
    int ec = -1, ic = -1, code;
    logic trap, isint;
    logic [31:0] pc;
    for (int i = 0; i < 14; i++) if (ec < 0 && e[EXC_PRI[i]]) ec = EXC_PRI[i];
    if (smie) for (int i = 0; i < 6; i++) if (ic < 0 && ip[INT_PRI[i]] && ie[INT_PRI[i]]) ic = INT_PRI[i];
    exc_req = e; mip_i = ip; mie_i = ie; mstatus_mie_i = smie; mstatus_mpie_i = smpie;
    epc_i = epc; tval_i = tval; mtvec_i = tvec; mepc_i = mepcv; mret = mr; pipe_clear = (stall == 0);
    step;
    clear_req;
    if (ec < 0 && ic < 0 && !mr) begin
      chk("no_req_busy", busy, 0);
      return;
    end
    trap = ec >= 0 || ic >= 0;
    isint = ec < 0 && ic >= 0;
    code = ec >= 0 ? ec : ic;
    chk("wait_busy", busy, 1);
    chk("wait_intr", intr, trap);
    repeat (stall) begin
      pipe_clear = 0;
      step;
      chk("stall_inject", inject, 0);
    end
    pipe_clear = 1;
    step;
    pipe_clear = 0;
    chk("commit_inject", inject, 1);
    chk("commit_insert", insert_pc, 0);
    chk("commit_intr", intr, trap);
    if (trap) begin
      m_cause = {isint, 27'b0, 4'(code)};
      m_epc = epc;
      m_tval = isint ? 32'h0 : tval;
    end
    chk("mcause", next_mcause, m_cause);
    chk("mepc", next_mepc, m_epc);
    chk("mtval", next_mtval, m_tval);
    chk("mstatus_mie", next_mstatus_mie, trap ? 1'b0 : smpie);
    chk("mstatus_mpie", next_mstatus_mpie, trap ? smie : 1'b1);
    pc = trap ? {tvec[31:2], 2'b00} : mepcv;
`ifdef TRAP_VECTORED_EN
    if (isint && tvec[1:0] == 2'b01) pc += 32'(4 * code);
`endif
    step;
    chk("redir_insert", insert_pc, 1);
    chk("redir_inject", inject, 0);
    chk("redir_intr", intr, trap);
    chk("priv_pc", priv_pc, pc);
    step;
    chk("back_busy", busy, 0);
    chk("back_insert", insert_pc, 0);
  endtask
  initial begin
    int inj;
    #12;
    chk_all_zero("reset");
    nRST = 1;
    step;
    txn(16'h0004, '0, '0, 0, 0, 32'h100, 32'hDEAD, 32'h1000, '0, 0, 0);
    txn(16'h000C, '0, '0, 0, 0, 32'h104, 32'h1, 32'h1000, '0, 0, 1);
    txn(16'h0050, '0, '0, 1, 0, 32'h108, 32'h2, 32'h1000, '0, 0, 0);
    txn('0, 12'h080, 12'h080, 1, 0, 32'h400, 32'hBEEF, 32'h1001, '0, 0, 0);
    txn('0, '0, '0, 0, 1, 32'h0, 32'h0, 32'h1001, 32'h2004, 1, 0);
    txn(16'h0800, 12'h800, 12'h800, 1, 1, 32'h500, 32'h9, 32'h3000, 32'h44, 1, 2);
    txn(16'h4400, '0, '0, 1, 1, 32'h600, 32'h9, 32'h3000, 32'h48, 0, 0);
    // Interrupt latched, then preempted by an exception while the pipe drains.
    clear_req;
    mstatus_mie_i = 1; mip_i = 12'h800; mie_i = 12'h800;
    epc_i = 32'h300; tval_i = 32'h55; mtvec_i = 32'h4000; pipe_clear = 0;
    step;
    mip_i = '0; mie_i = '0; inj = 0;
    chk("pre_intr", intr, 1);
    for (int k = 0; k < 5; k++) begin
      exc_req = (k == 2) ? 16'h0100 : 16'h0;
      if (k == 2) begin epc_i = 32'h304; tval_i = 32'h77; end
      step;
      inj += int'(inject);
    end
    exc_req = '0;
    chk("pre_no_inject", inj, 0);
    pipe_clear = 1;
    step;
    pipe_clear = 0;
    m_cause = 32'h8; m_epc = 32'h304; m_tval = 32'h77;
    chk("pre_inject", inject, 1);
    chk("pre_mcause", next_mcause, m_cause);
    chk("pre_mepc", next_mepc, m_epc);
    chk("pre_mtval", next_mtval, m_tval);
    chk("pre_mie", next_mstatus_mie, 0);
    chk("pre_mpie", next_mstatus_mpie, 1);
    step;
    chk("pre_insert", insert_pc, 1);
    chk("pre_inject_once", inject, 0);
    chk("pre_pc", priv_pc, 32'h4000);
    step;
    chk("pre_idle", busy, 0);
    // Asynchronous reset while waiting for the drain.
    exc_req = 16'h0004; epc_i = 32'h700; tval_i = 32'h1;
    step;
    exc_req = '0;
    chk("rst_mid_busy", busy, 1);
    #2 nRST = 0;
    #1 chk_all_zero("rst_mid");
    #2 nRST = 1;
    m_cause = '0; m_epc = '0; m_tval = '0;
    repeat (3) begin
      step;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_inject", inject, 0);
      chk("post_rst_insert", insert_pc, 0);
    end
    for (int t = 0; t < 40; t++) begin
      logic [15:0] e;
      int r = $urandom_range(0, 3);
      e = r == 0 ? 16'($urandom) : r == 1 ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      txn(e, 12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
